// File: rtl/aes_pkg.sv
// Shared AES widths, GF(2^8) helpers, FSM encoding and the InvShiftRows byte map
// used by the decryption-side InvShiftRows/InvMixColumns stage.
package aes_pkg;

    localparam int STATE_W  = 128;
    localparam int COL_BITS = 32;
    localparam int BYTE_W   = 8;
    localparam int NBYTES   = STATE_W / BYTE_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_e;

    // Multiply by x modulo the AES polynomial 0x11B.
    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
        return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [BYTE_W-1:0] gf_mul9(input logic [BYTE_W-1:0] a);
        logic [BYTE_W-1:0] x8;
        x8 = xtime(xtime(xtime(a)));
        return x8 ^ a;
    endfunction

    function automatic logic [BYTE_W-1:0] gf_mul11(input logic [BYTE_W-1:0] a);
        logic [BYTE_W-1:0] x2;
        logic [BYTE_W-1:0] x8;
        x2 = xtime(a);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ a;
    endfunction

    function automatic logic [BYTE_W-1:0] gf_mul13(input logic [BYTE_W-1:0] a);
        logic [BYTE_W-1:0] x4;
        logic [BYTE_W-1:0] x8;
        x4 = xtime(xtime(a));
        x8 = xtime(x4);
        return x8 ^ x4 ^ a;
    endfunction

    function automatic logic [BYTE_W-1:0] gf_mul14(input logic [BYTE_W-1:0] a);
        logic [BYTE_W-1:0] x2;
        logic [BYTE_W-1:0] x4;
        logic [BYTE_W-1:0] x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // Byte i = 4*col + row; the output byte at (row, col) comes from (row, col-row mod 4).
    function automatic int inv_shift_src(input int idx);
        int row;
        int col;
        row = idx % 4;
        col = idx / 4;
        return 4 * ((col - row + 4) % 4) + row;
    endfunction

    function automatic logic [STATE_W-1:0] inv_shift_rows(input logic [STATE_W-1:0] s);
        logic [STATE_W-1:0] r;
        r = '0;
        for (int i = 0; i < NBYTES; i++) begin
            r[STATE_W-1-BYTE_W*i -: BYTE_W] = s[STATE_W-1-BYTE_W*inv_shift_src(i) -: BYTE_W];
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_mixcolumn_col.sv
// Combinational InvMixColumns for a single 32-bit column; row 0 is the top byte.
module aes_inv_mixcolumn_col
    import aes_pkg::*;
(
    input  logic [COL_BITS-1:0] col_in,
    output logic [COL_BITS-1:0] col_out
);
    logic [BYTE_W-1:0] a0;
    logic [BYTE_W-1:0] a1;
    logic [BYTE_W-1:0] a2;
    logic [BYTE_W-1:0] a3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    assign col_out = {
        gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3),
        gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3),
        gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3),
        gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3)
    };

endmodule

// File: rtl/aes_inv_shiftrow_mixcol.sv
// InvShiftRows on accept, then InvMixColumns one column per cycle (skipped on the
// final round), with valid/ready handshakes and a single state in flight.
module aes_inv_shiftrow_mixcol
    import aes_pkg::*;
#(
    parameter int NCOL = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state
);
    localparam int COL_W = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NCOL - 1);

    fsm_state_e          state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [STATE_W-1:0]  work_q, work_d;
    logic                last_q, last_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [COL_BITS-1:0] col_cur;
    logic [COL_BITS-1:0] col_mixed;

    always_comb begin
        col_cur = '0;
        for (int c = 0; c < NCOL; c++) begin
            if (col_q == COL_W'(c)) begin
                col_cur = work_q[STATE_W-1-COL_BITS*c -: COL_BITS];
            end
        end
    end

    aes_inv_mixcolumn_col u_mix (
        .col_in  (col_cur),
        .col_out (col_mixed)
    );

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        work_d      = work_q;
        last_d      = last_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    work_d     = inv_shift_rows(in_state);
                    last_d     = in_last;
                    col_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = ST_CALC;
                end
            end
            ST_CALC: begin
                // The final round still spends the four column cycles so latency is fixed.
                for (int c = 0; c < NCOL; c++) begin
                    if (col_q == COL_W'(c)) begin
                        work_d[STATE_W-1-COL_BITS*c -: COL_BITS] = last_q ? col_cur : col_mixed;
                    end
                end
                col_d = col_q + COL_W'(1);
                if (col_q == LAST_COL) begin
                    col_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            work_q      <= '0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            work_q      <= work_d;
            last_q      <= last_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = work_q;

endmodule

// File: tb/tb_aes_inv_shiftrow_mixcol.sv
// Scoreboard bench: the driver pushes reference results on each accept, and a
// negedge monitor compares them, plus the accept-to-valid latency, as outputs appear.
module tb_aes_inv_shiftrow_mixcol;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    int checks;
    int failures;
    int cyc;
    int last_accept_cyc;
    logic prev_valid;
    logic [127:0] exp_q[$];
    int accept_q[$];

    aes_inv_shiftrow_mixcol #(.NCOL(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Generic shift-and-add multiply with long-division reduction by 0x11B.
    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (16'(a) << i);
        end
        for (int i = 15; i >= 8; i--) begin
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        end
        return p[7:0];
    endfunction

    function automatic logic [127:0] refModel(input logic [127:0] st, input logic last);
        logic [7:0] m[4][4];
        logic [7:0] s[4][4];
        logic [7:0] b;
        logic [127:0] res;
        int coef[4];
        coef = '{14, 11, 13, 9};
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = st[127-8*(4*c+r) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = m[r][(c - r + 4) % 4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (last) begin
                    b = s[r][c];
                end else begin
                    b = 8'h00;
                    for (int k = 0; k < 4; k++) b = b ^ gfMul(8'(coef[(k - r + 4) % 4]), s[k][c]);
                end
                res[127-8*(4*c+r) -: 8] = b;
            end
        end
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [127:0] st, input logic last, input logic [127:0] expected);
        int wait_cycles;
        wait_cycles = 0;
        in_state = st;
        in_last  = last;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && wait_cycles < 40) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout actual=in_ready_low required=accept_within_40");
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(expected);
            accept_q.push_back(cyc + 1);
            last_accept_cyc = cyc + 1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        checkOutput("drain_pending", 128'(exp_q.size()), 128'(0));
    endtask

    // Monitor: latency on each rising out_valid, value on every valid cycle.
    initial prev_valid = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (accept_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL spurious_valid actual=out_valid_high required=no_pending_accept");
                end else begin
                    checkOutput("latency", 128'(cyc - accept_q.pop_front()), 128'(4));
                end
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL spurious_output actual=%h required=none", out_state);
                end else if (out_ready) begin
                    checkOutput("out_state", out_state, exp_q.pop_front());
                end else begin
                    checkOutput("stall_state", out_state, exp_q[0]);
                end
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        logic [127:0] v;
        logic lst;
        int prev_acc;
        checks = 0;
        failures = 0;
        last_accept_cyc = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_state = '0;
        in_last = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", 128'(in_ready), 128'(0));
        checkOutput("reset_out_valid", 128'(out_valid), 128'(0));
        checkOutput("reset_out_state", out_state, 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("post_reset_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;

        $display("[TB] known vectors");
        applyStimulus({4{32'h8e4da1bc}}, 1'b0, {4{32'hdb135345}});
        waitDrain();
        applyStimulus({4{32'h9fdc589d}}, 1'b0, {4{32'hf20a225c}});
        waitDrain();
        applyStimulus({4{32'h01010101}}, 1'b0, {4{32'h01010101}});
        waitDrain();
        applyStimulus(128'h000102030405060708090a0b0c0d0e0f, 1'b1, 128'h000d0a07_04010e0b_0805020f_0c090603);
        waitDrain();

        $display("[TB] random vectors with random output delay");
        for (int i = 0; i < 16; i++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            lst = 1'($urandom_range(0, 1));
            out_ready = 1'b0;
            applyStimulus(v, lst, refModel(v, lst));
            repeat ($urandom_range(0, 8)) @(posedge clk);
            #1;
            out_ready = 1'b1;
            waitDrain();
        end

        $display("[TB] backpressure with ignored in_valid");
        v = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b0;
        applyStimulus(v, 1'b0, refModel(v, 1'b0));
        in_valid = 1'b1;
        in_state = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 128'(in_ready), 128'(0));
        end
        checkOutput("bp_out_valid", 128'(out_valid), 128'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        waitDrain();

        $display("[TB] back-to-back");
        for (int i = 0; i < 5; i++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            lst = 1'($urandom_range(0, 1));
            prev_acc = last_accept_cyc;
            applyStimulus(v, lst, refModel(v, lst));
            if (i > 0) checkOutput("b2b_gap", 128'(last_accept_cyc - prev_acc), 128'(6));
        end
        waitDrain();

        $display("[TB] reset mid-calc");
        v = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(v, 1'b0, refModel(v, 1'b0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        accept_q.delete();
        @(negedge clk);
        checkOutput("midrst_out_valid", 128'(out_valid), 128'(0));
        checkOutput("midrst_out_state", out_state, 128'(0));
        checkOutput("midrst_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_in_ready_after", 128'(in_ready), 128'(1));
        checkOutput("midrst_out_valid_after", 128'(out_valid), 128'(0));
        @(posedge clk);
        #1;
        applyStimulus({4{32'h8e4da1bc}}, 1'b0, {4{32'hdb135345}});
        waitDrain();

        repeat (10) @(posedge clk);
        #1;
        checkOutput("final_queue_empty", 128'(exp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
